// File: rtl/run_ctrl_pkg.sv
// Shared opcode and state encodings for the CPU run-control sequencer.
package run_ctrl_pkg;

  localparam logic [1:0] OP_HALT = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_RUNN = 2'b11;

  typedef enum logic [2:0] {
    S_RST,
    S_HALT,
    S_RUN,
    S_STEP,
    S_RUNN
  } state_e;

endpackage

// File: rtl/bp_match.sv
// NUM_BP parallel PC comparators; hit[i] is set when breakpoint i is enabled and matches.
module bp_match #(
  parameter int unsigned NUM_BP = 2,
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0]        pc,
  input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]        bp_en,
  output logic [NUM_BP-1:0]        hit
);

  for (genvar i = 0; i < NUM_BP; i++) begin : g_cmp
    assign hit[i] = bp_en[i] && (pc == bp_addr[i*ADDR_W +: ADDR_W]);
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: core reset pulse, clock enable, step/run/run-N and cycle counting.
// PC breakpoints are built only when RUN_CTRL_BREAKPOINT_EN is defined.
module cpu_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned NUM_BP     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [CNT_W-1:0]         cmd_count,
  input  logic [ADDR_W-1:0]        cpu_pc,
  output logic                     cpu_rst,
  output logic                     cpu_ce,
  output logic                     halted,
  output logic [CNT_W-1:0]         cycle_cnt,
  input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]        bp_en,
  output logic [NUM_BP-1:0]        bp_hit
);

  localparam int unsigned RW = $clog2(RST_CYCLES + 1);

  state_e           state, state_nxt;
  logic [RW-1:0]    rst_cnt;
  logic [CNT_W-1:0] remaining;
  logic             ce_q;
  logic             accept;
  logic             bp_stop;

  assign accept = cmd_valid && cmd_ready;
  assign cpu_ce = ce_q && !bp_stop;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_RST:  if (rst_cnt == RW'(RST_CYCLES - 1)) state_nxt = S_HALT;
      S_HALT: begin
        if (accept) begin
          unique case (cmd_op)
            OP_RUN:  state_nxt = S_RUN;
            OP_STEP: state_nxt = S_STEP;
            OP_RUNN: if (cmd_count != '0) state_nxt = S_RUNN;
            default: state_nxt = S_HALT;
          endcase
        end
      end
      S_RUN:  if (bp_stop || (accept && cmd_op == OP_HALT)) state_nxt = S_HALT;
      S_STEP: state_nxt = S_HALT;
      S_RUNN: begin
        if (bp_stop || (accept && cmd_op == OP_HALT) || remaining == CNT_W'(1)) begin
          state_nxt = S_HALT;
        end
      end
      default: state_nxt = S_RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_RST;
      rst_cnt   <= '0;
      remaining <= '0;
      ce_q      <= 1'b0;
      cpu_rst   <= 1'b1;
      halted    <= 1'b0;
      cmd_ready <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      state     <= state_nxt;
      ce_q      <= (state_nxt == S_RUN) || (state_nxt == S_STEP) || (state_nxt == S_RUNN);
      cpu_rst   <= (state_nxt == S_RST);
      halted    <= (state_nxt == S_HALT);
      cmd_ready <= (state_nxt == S_HALT) || (state_nxt == S_RUN) || (state_nxt == S_RUNN);
      if (cpu_ce) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (state == S_RST) rst_cnt <= rst_cnt + RW'(1);
      if (state == S_HALT && state_nxt == S_RUNN) begin
        remaining <= cmd_count;
      end else if (state == S_RUNN) begin
        remaining <= remaining - CNT_W'(1);
      end
    end
  end

`ifdef RUN_CTRL_BREAKPOINT_EN
  logic              skip;
  logic [NUM_BP-1:0] hit_vec;

  bp_match #(
    .NUM_BP (NUM_BP),
    .ADDR_W (ADDR_W)
  ) u_bp_match (
    .pc      (cpu_pc),
    .bp_addr (bp_addr),
    .bp_en   (bp_en),
    .hit     (hit_vec)
  );

  // First enabled cycle after leaving halt ignores matches so resume makes progress.
  assign bp_stop = ((state == S_RUN) || (state == S_RUNN)) && !skip && (|hit_vec);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skip   <= 1'b0;
      bp_hit <= '0;
    end else begin
      skip <= (state == S_HALT) && ((state_nxt == S_RUN) || (state_nxt == S_RUNN));
      if (bp_stop) begin
        bp_hit <= bp_hit | hit_vec;
      end else if (accept && cmd_op != OP_HALT) begin
        bp_hit <= '0;
      end
    end
  end
`else
  logic unused_bp;

  assign unused_bp = ^{cpu_pc, bp_addr, bp_en};
  assign bp_stop   = 1'b0;
  assign bp_hit    = '0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed, table-driven self-checking bench for cpu_run_ctrl.
module tb_cpu_run_ctrl;
  import run_ctrl_pkg::*;

  localparam int unsigned RST_CYCLES = 4;
  localparam int unsigned CNT_W      = 32;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned NUM_BP     = 2;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [1:0]               cmd_op;
  logic [CNT_W-1:0]         cmd_count;
  logic [ADDR_W-1:0]        pc;
  logic                     cpu_rst;
  logic                     cpu_ce;
  logic                     halted;
  logic [CNT_W-1:0]         cycle_cnt;
  logic [NUM_BP*ADDR_W-1:0] bp_addr;
  logic [NUM_BP-1:0]        bp_en;
  logic [NUM_BP-1:0]        bp_hit;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  cpu_run_ctrl #(
    .RST_CYCLES (RST_CYCLES),
    .CNT_W      (CNT_W),
    .ADDR_W     (ADDR_W),
    .NUM_BP     (NUM_BP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_count (cmd_count),
    .cpu_pc    (pc),
    .cpu_rst   (cpu_rst),
    .cpu_ce    (cpu_ce),
    .halted    (halted),
    .cycle_cnt (cycle_cnt),
    .bp_addr   (bp_addr),
    .bp_en     (bp_en),
    .bp_hit    (bp_hit)
  );

  always #5 clk = ~clk;

  // Simple core model: PC advances by 4 on every enabled cycle.
  always @(posedge clk or negedge rst) begin
    if (!rst) pc <= '0;
    else if (cpu_ce) pc <= pc + 32'd4;
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] count;
    int          pulses;
    logic        ready_first;
  } vec_t;

  vec_t tv[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [31:0] count);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = count;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic reset_seq();
    rst = 1'b0;
    #1;
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_cpu_ce", cpu_ce, 0);
    check("rst_halted", halted, 0);
    check("rst_ready", cmd_ready, 0);
    check("rst_cycle_cnt", cycle_cnt, 0);
    check("rst_bp_hit", bp_hit, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= RST_CYCLES; i++) begin
      @(negedge clk);
      check("rst_hold", cpu_rst, (i < RST_CYCLES) ? 1 : 0);
    end
    check("post_rst_halted", halted, 1);
    check("post_rst_ce", cpu_ce, 0);
    check("post_rst_ready", cmd_ready, 1);
    check("post_rst_cycle_cnt", cycle_cnt, 0);
    exp_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pulses;
    int rises;
    logic prev;
    int guard;

    tv[0] = '{OP_STEP, 32'd0,  1,  1'b0};
    tv[1] = '{OP_STEP, 32'd0,  1,  1'b0};
    tv[2] = '{OP_STEP, 32'd0,  1,  1'b0};
    tv[3] = '{OP_RUNN, 32'd10, 10, 1'b1};
    tv[4] = '{OP_RUNN, 32'd0,  0,  1'b1};
    tv[5] = '{OP_RUNN, 32'd1,  1,  1'b1};
    tv[6] = '{OP_HALT, 32'd0,  0,  1'b1};
    tv[7] = '{OP_RUNN, 32'd3,  3,  1'b1};
    tv[8] = '{OP_STEP, 32'd7,  1,  1'b0};

    cmd_valid = 1'b0;
    cmd_op    = OP_HALT;
    cmd_count = '0;
    bp_addr   = {32'h0000_0014, 32'h0000_0010};
    bp_en     = '0;

    @(negedge clk);
    reset_seq();

    for (int v = 0; v < 9; v++) begin
      send(tv[v].op, tv[v].count);
      check("ready_first", cmd_ready, tv[v].ready_first);
      check("ce_latency", cpu_ce, (tv[v].pulses != 0) ? 1 : 0);
      pulses = cpu_ce ? 1 : 0;
      rises  = pulses;
      prev   = cpu_ce;
      repeat (13) begin
        @(negedge clk);
        if (cpu_ce) pulses++;
        if (cpu_ce && !prev) rises++;
        prev = cpu_ce;
      end
      exp_cnt += tv[v].pulses;
      check("vec_pulses", pulses, tv[v].pulses);
      check("vec_contig", rises, (tv[v].pulses != 0) ? 1 : 0);
      check("vec_halted", halted, 1);
      check("vec_cycle_cnt", cycle_cnt, exp_cnt);
    end

    // RUN, then HALT accepted 7 edges later.
    send(OP_RUN, 32'd0);
    check("run_ce", cpu_ce, 1);
    check("run_halted", halted, 0);
    repeat (6) @(negedge clk);
    send(OP_HALT, 32'd0);
    exp_cnt += 7;
    check("halt_ce_drop", cpu_ce, 0);
    check("halt_halted", halted, 1);
    check("run7_cycle_cnt", cycle_cnt, exp_cnt);

    // HALT accepted on the same edge RUNN(3) expires.
    send(OP_RUNN, 32'd3);
    repeat (2) @(negedge clk);
    send(OP_HALT, 32'd0);
    exp_cnt += 3;
    check("coinc_ce", cpu_ce, 0);
    check("coinc_halted", halted, 1);
    @(negedge clk);
    check("coinc_cycle_cnt", cycle_cnt, exp_cnt);

    // Async reset in the middle of RUNN(10) with 5 cycles remaining.
    send(OP_RUNN, 32'd10);
    repeat (5) @(negedge clk);
    check("midrunn_cycle_cnt", cycle_cnt, exp_cnt + 5);
    reset_seq();

`ifdef RUN_CTRL_BREAKPOINT_EN
    bp_en = 2'b01;
    send(OP_RUN, 32'd0);
    guard = 0;
    while (!halted && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("bp_timeout", (guard < 20) ? 1 : 0, 1);
    check("bp_pc", pc, 32'h10);
    check("bp_cycle_cnt", cycle_cnt, 4);
    check("bp_hit", bp_hit, 2'b01);
    check("bp_ce", cpu_ce, 0);
    send(OP_STEP, 32'd0);
    check("bp_hit_clear", bp_hit, 2'b00);
    @(negedge clk);
    check("bp_step_pc", pc, 32'h14);
    check("bp_step_cycle_cnt", cycle_cnt, 5);
    check("bp_step_halted", halted, 1);
`else
    guard = 0;
    bp_en = 2'b11;
    send(OP_RUNN, 32'd6);
    repeat (8) begin
      @(negedge clk);
      guard++;
    end
    check("nobp_cycle_cnt", cycle_cnt, 6);
    check("nobp_hit", bp_hit, 0);
    check("nobp_halted", halted, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
